// File: rtl/knn_nearest_selector_if.sv
// -----------------------------------------------------------------------------
// knn_nearest_selector_if
//   Groups the query-control, distance-stream and drain handshake signals of
//   knn_nearest_selector into one bundle.
//
//   master : the side that starts queries, streams distances and accepts the
//            drained list (accumulator / classifier / testbench).
//   slave  : the selector itself.
//
//   Signals
//     start, numPoints           query start pulse and vector count
//     distance, distanceValid    distance stream from the accumulator
//     label                      class of the current vector (KNN_SELECT_LABEL_EN)
//     result_distance/index      drained entry
//     result_label               drained label (KNN_SELECT_LABEL_EN)
//     result_valid/ready/last    drain handshake, last marks the final entry
//     busy, done                 query status
//
//   Optional feature macro: KNN_SELECT_LABEL_EN adds the label signals.
// -----------------------------------------------------------------------------
interface knn_nearest_selector_if #(
  parameter int dataWidth  = 32,
  parameter int indexWidth = 16
`ifdef KNN_SELECT_LABEL_EN
  ,
  parameter int labelWidth = 8
`endif
);

  logic                  start;
  logic [indexWidth-1:0] numPoints;
  logic [dataWidth-1:0]  distance;
  logic                  distanceValid;
`ifdef KNN_SELECT_LABEL_EN
  logic [labelWidth-1:0] label;
  logic [labelWidth-1:0] result_label;
`endif
  logic [dataWidth-1:0]  result_distance;
  logic [indexWidth-1:0] result_index;
  logic                  result_valid;
  logic                  result_ready;
  logic                  result_last;
  logic                  busy;
  logic                  done;

  modport master (
    output start, numPoints, distance, distanceValid, result_ready,
`ifdef KNN_SELECT_LABEL_EN
    output label,
    input  result_label,
`endif
    input  result_distance, result_index, result_valid, result_last,
    input  busy, done
  );

  modport slave (
    input  start, numPoints, distance, distanceValid, result_ready,
`ifdef KNN_SELECT_LABEL_EN
    input  label,
    output result_label,
`endif
    output result_distance, result_index, result_valid, result_last,
    output busy, done
  );

endinterface

// File: rtl/knn_nearest_selector.sv
// -----------------------------------------------------------------------------
// knn_nearest_selector
//   Sits downstream of the distance accumulator. For one query it accepts
//   numPoints distances, keeps the k smallest in an ascending list (each with
//   the index of its training vector), then drains that list in order over a
//   valid/ready port.
//
//   Ports
//     clk    : clock
//     reset  : synchronous, active-high; aborts any query (no done pulse)
//     bus    : knn_nearest_selector_if.slave
//                start/numPoints      begin a query (numPoints sampled on start)
//                distance/distanceValid  distance stream, used only in COLLECT
//                result_*             drained entries, 0 outside DRAIN
//                busy                 high in COLLECT or DRAIN
//                done                 one-cycle pulse after the final transfer
//
//   Optional feature macro: KNN_SELECT_LABEL_EN
//     Adds a per-slot label that moves with its distance and is drained on
//     result_label. Without it there is no label storage at all.
//
//   Sequencing: IDLE -> COLLECT -> DRAIN -> DONE -> IDLE. DONE is the single
//   cycle that carries the done pulse; start is not accepted there, so a start
//   coinciding with done is ignored.
// -----------------------------------------------------------------------------
module knn_nearest_selector #(
  parameter int dataWidth  = 32,
  parameter int k          = 4,
  parameter int indexWidth = 16
`ifdef KNN_SELECT_LABEL_EN
  ,
  parameter int labelWidth = 8
`endif
) (
  input logic                   clk,
  input logic                   reset,
  knn_nearest_selector_if.slave bus
);

  localparam int PTR_W = (k > 1) ? $clog2(k) : 1;
  localparam logic [indexWidth-1:0] K_LAST = indexWidth'(k - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state;
  logic [indexWidth-1:0] count;
  logic [indexWidth-1:0] num_points_q;
  logic [PTR_W-1:0]      ptr;

  // Ascending list; occupied slots always form a prefix.
  logic [dataWidth-1:0]  slot_dist [k];
  logic [indexWidth-1:0] slot_idx  [k];
  logic [k-1:0]          slot_occ;
  logic [dataWidth-1:0]  nxt_dist  [k];
  logic [indexWidth-1:0] nxt_idx   [k];
  logic [k-1:0]          nxt_occ;
  logic [k-1:0]          qualify;
`ifdef KNN_SELECT_LABEL_EN
  logic [labelWidth-1:0] slot_lbl  [k];
  logic [labelWidth-1:0] nxt_lbl   [k];
`endif

  logic in_drain;
  logic last_entry;
  logic transfer;

  // Final drain pointer: min(k, numPoints) - 1. numPoints is never 0 here.
  function automatic logic [indexWidth-1:0] last_ptr_f(input logic [indexWidth-1:0] n);
    return (n > K_LAST) ? K_LAST : (n - indexWidth'(1));
  endfunction

  assign in_drain   = (state == DRAIN);
  assign last_entry = in_drain && (indexWidth'(ptr) == last_ptr_f(num_points_q));
  assign transfer   = in_drain && bus.result_ready;

  // Parallel compare and shift. Because the list is sorted with occupied
  // slots first, qualify is monotonic: once a slot qualifies, every later
  // slot does too. The first qualifying slot takes the new entry and each
  // later qualifying slot takes its predecessor; the old slot[k-1] falls off.
  // Strict less-than keeps equal distances in arrival (index) order.
  always_comb begin
    for (int j = 0; j < k; j++) begin
      qualify[j]  = !slot_occ[j] || (bus.distance < slot_dist[j]);
      nxt_dist[j] = slot_dist[j];
      nxt_idx[j]  = slot_idx[j];
      nxt_occ[j]  = slot_occ[j];
`ifdef KNN_SELECT_LABEL_EN
      nxt_lbl[j]  = slot_lbl[j];
`endif
    end
    if (qualify[0]) begin
      nxt_dist[0] = bus.distance;
      nxt_idx[0]  = count;
      nxt_occ[0]  = 1'b1;
`ifdef KNN_SELECT_LABEL_EN
      nxt_lbl[0]  = bus.label;
`endif
    end
    for (int j = 1; j < k; j++) begin
      if (qualify[j]) begin
        if (qualify[j-1]) begin
          nxt_dist[j] = slot_dist[j-1];
          nxt_idx[j]  = slot_idx[j-1];
          nxt_occ[j]  = slot_occ[j-1];
`ifdef KNN_SELECT_LABEL_EN
          nxt_lbl[j]  = slot_lbl[j-1];
`endif
        end else begin
          nxt_dist[j] = bus.distance;
          nxt_idx[j]  = count;
          nxt_occ[j]  = 1'b1;
`ifdef KNN_SELECT_LABEL_EN
          nxt_lbl[j]  = bus.label;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      num_points_q <= '0;
      ptr          <= '0;
      slot_occ     <= '0;
      for (int j = 0; j < k; j++) begin
        slot_dist[j] <= '1;
        slot_idx[j]  <= '0;
`ifdef KNN_SELECT_LABEL_EN
        slot_lbl[j]  <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (bus.numPoints != '0)) begin
            state        <= COLLECT;
            count        <= '0;
            num_points_q <= bus.numPoints;
            ptr          <= '0;
            slot_occ     <= '0;
            for (int j = 0; j < k; j++) begin
              slot_dist[j] <= '1;
              slot_idx[j]  <= '0;
`ifdef KNN_SELECT_LABEL_EN
              slot_lbl[j]  <= '0;
`endif
            end
          end
        end
        COLLECT: begin
          if (bus.distanceValid) begin
            slot_occ <= nxt_occ;
            for (int j = 0; j < k; j++) begin
              slot_dist[j] <= nxt_dist[j];
              slot_idx[j]  <= nxt_idx[j];
`ifdef KNN_SELECT_LABEL_EN
              slot_lbl[j]  <= nxt_lbl[j];
`endif
            end
            count <= count + indexWidth'(1);
            if (count == (num_points_q - indexWidth'(1))) begin
              state <= DRAIN;
              ptr   <= '0;
            end
          end
        end
        DRAIN: begin
          if (transfer) begin
            if (last_entry) state <= DONE;
            else            ptr   <= ptr + PTR_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state; result_* hold while stalled
  // because ptr and the slots only change on a transfer.
  assign bus.result_valid    = in_drain;
  assign bus.result_distance = in_drain ? slot_dist[ptr] : '0;
  assign bus.result_index    = in_drain ? slot_idx[ptr]  : '0;
  assign bus.result_last     = last_entry;
`ifdef KNN_SELECT_LABEL_EN
  assign bus.result_label    = in_drain ? slot_lbl[ptr]  : '0;
`endif
  assign bus.busy            = (state == COLLECT) || in_drain;
  assign bus.done            = (state == DONE);

endmodule

// File: tb/tb_knn_nearest_selector.sv
module tb_knn_nearest_selector;

  localparam int DW = 32;
  localparam int K  = 4;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  knn_nearest_selector_if #(.dataWidth(DW), .indexWidth(IW)) bus ();

  knn_nearest_selector #(.dataWidth(DW), .k(K), .indexWidth(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] sent_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    bus.numPoints = IW'(n);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic start_q(input int n);
    sent_q.delete();
    pulse_start(n);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit record);
    bus.distance      = d;
    bus.distanceValid = 1'b1;
    tick();
    bus.distanceValid = 1'b0;
    if (record) sent_q.push_back(d);
  endtask

  // Reference: repeated minimum search over everything sent this query;
  // strict '<' keeps the earliest index on ties.
  task automatic push_expected(input int n);
    int  m;
    bit  picked[$];
    exp_t e;
    m = (n < K) ? n : K;
    picked.delete();
    foreach (sent_q[j]) picked.push_back(1'b0);
    for (int r = 0; r < m; r++) begin
      int best = -1;
      foreach (sent_q[j])
        if (!picked[j] && (best < 0 || sent_q[j] < sent_q[best])) best = j;
      picked[best] = 1'b1;
      e.d = sent_q[best];
      e.i = IW'(best);
      e.last = (r == m - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, bus.result_valid, 1'b0);
    check({tag, "_dist"},  bus.result_distance, '0);
    check({tag, "_index"}, bus.result_index, '0);
    check({tag, "_last"},  bus.result_last, 1'b0);
    check({tag, "_busy"},  bus.busy, 1'b0);
    check({tag, "_done"},  bus.done, 1'b0);
  endtask

  task automatic drain(input string tag, input int hold, input bit start_on_done);
    int   waitc = 0;
    int   cnt0;
    exp_t e;
    while (bus.result_valid !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, "_valid_seen"}, bus.result_valid, 1'b1);
    if (bus.result_valid !== 1'b1) begin
      exp_q.delete();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_dist"},  bus.result_distance, exp_q[0].d);
      check({tag, "_hold_index"}, bus.result_index, exp_q[0].i);
      check({tag, "_hold_valid"}, bus.result_valid, 1'b1);
      tick();
    end
    bus.result_ready = 1'b1;
    cnt0 = done_cnt;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, bus.result_valid, 1'b1);
      check({tag, "_dist"},  bus.result_distance, e.d);
      check({tag, "_index"}, bus.result_index, e.i);
      check({tag, "_last"},  bus.result_last, e.last);
      tick();
    end
    bus.result_ready = 1'b0;
    check({tag, "_done_pulse"}, bus.done, 1'b1);
    check({tag, "_valid_after"}, bus.result_valid, 1'b0);
    if (start_on_done) begin
      bus.numPoints = IW'(1);
      bus.start     = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    check({tag, "_done_once"}, done_cnt, cnt0 + 1);
    check_idle_outputs({tag, "_post"});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    bus.start = 1'b0;
    bus.numPoints = '0;
    bus.distance = '0;
    bus.distanceValid = 1'b0;
    bus.result_ready = 1'b0;
`ifdef KNN_SELECT_LABEL_EN
    bus.label = '0;
`endif
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Directed query from the reference example.
    start_q(6);
    check("t1_busy", bus.busy, 1'b1);
    send(50, 1); send(10, 1); send(40, 1); send(30, 1); send(20, 1);
    check("t1_valid_early", bus.result_valid, 1'b0);
    send(60, 1);
    check("t1_valid_latency", bus.result_valid, 1'b1);
    push_expected(6);
    drain("t1", 0, 1'b0);

    // Fewer points than k.
    start_q(2);
    send(7, 1); send(3, 1);
    push_expected(2);
    drain("t2", 0, 1'b0);

    // Ties keep arrival order; the fifth equal value is dropped.
    start_q(5);
    for (int j = 0; j < 5; j++) send(5, 1);
    push_expected(5);
    drain("t3", 0, 1'b0);

    // Backpressure, with a start coinciding with done.
    start_q(4);
    send(9, 1); send(2, 1); send(6, 1); send(4, 1);
    push_expected(4);
    drain("t4", 5, 1'b1);
    check("t4_start_on_done_ignored", bus.busy, 1'b0);

    // All-ones distances still occupy empty slots.
    start_q(2);
    send('1, 1); send('1, 1);
    push_expected(2);
    drain("allones", 0, 1'b0);

    // Reset mid-query.
    start_q(6);
    send(11, 1); send(12, 1); send(13, 1);
    c0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("t5_reset");
    tick(); tick(); tick();
    check("t5_no_done", done_cnt, c0);
    start_q(2);
    send(9, 1); send(4, 1);
    push_expected(2);
    drain("t5_new", 0, 1'b0);

    // Ignored stimulus: distances in IDLE, start while busy, numPoints == 0.
    send(1, 0); send(2, 0);
    check("t6_idle_dv_busy", bus.busy, 1'b0);
    check("t6_idle_dv_valid", bus.result_valid, 1'b0);
    start_q(3);
    send(1, 1);
    pulse_start(1);
    send(8, 1); send(4, 1);
    push_expected(3);
    drain("t6_busy_start", 0, 1'b0);
    c0 = done_cnt;
    pulse_start(0);
    check("t6_zero_busy", bus.busy, 1'b0);
    tick(); tick();
    check("t6_zero_valid", bus.result_valid, 1'b0);
    check("t6_zero_no_done", done_cnt, c0);

    // Longer random query with frequent ties.
    start_q(12);
    for (int j = 0; j < 12; j++) send(DW'($urandom_range(0, 7)), 1);
    push_expected(12);
    drain("rand", 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
